// File: rtl/gf22_sram64_arb_pkg.sv
// rtl/gf22_sram64_arb_pkg.sv - shared defaults, FSM states and clear-sweep helper for the SRAM arbiter
package gf22_sram64_arb_pkg;

    localparam int AW_DEF = 14;
    localparam int DW_DEF = 64;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    // Last address written by the zero-fill sweep for a memory of depth 2^aw.
    function automatic logic [31:0] clear_last(input int aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

endpackage

// File: rtl/gf22_rr_arbiter.sv
// rtl/gf22_rr_arbiter.sv - N-way round-robin grant with pointer advance on accept
module gf22_rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_id,
    output logic          gnt_any
);

    logic [PW-1:0] ptr_q;
    int            idx;

    // Pick the first requester at or after the pointer, wrapping cyclically.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        gnt     = '0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = PW'(idx);
            end
        end
        if (gnt_any) gnt[gnt_id] = 1'b1;
    end

    // Priority moves just past the winner only when the grant is actually taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/gf22_sram64_be_arbiter.sv
// rtl/gf22_sram64_be_arbiter.sv - shares one byte-masked 1W/1R SRAM between NREQ requesters with zero-fill engine
module gf22_sram64_be_arbiter
    import gf22_sram64_arb_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int AW             = AW_DEF,
    parameter int DW             = DW_DEF,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_req,
    output logic               clear_busy,
    input  logic [NREQ-1:0]    wr_valid,
    output logic [NREQ-1:0]    wr_ready,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
    input  logic [NREQ*DW-1:0] wr_mask,
    input  logic [NREQ-1:0]    rd_valid,
    output logic [NREQ-1:0]    rd_ready,
    input  logic [NREQ*AW-1:0] rd_addr,
    output logic [NREQ-1:0]    rd_rsp_valid,
    output logic [DW-1:0]      rd_rsp_data,
    output logic               mem_ce0,
    output logic [AW-1:0]      mem_a0,
    output logic [DW-1:0]      mem_d0,
    output logic               mem_we0,
    output logic [DW-1:0]      mem_wem0,
    output logic               mem_ce1,
    output logic [AW-1:0]      mem_a1,
    input  logic [DW-1:0]      mem_q1
);

    localparam int              PW       = $clog2(NREQ);
    localparam logic [AW-1:0]   CLR_LAST = AW'(clear_last(AW));
    localparam arb_state_e      RST_ST   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    arb_state_e      state_q, state_d;
    logic [AW-1:0]   clr_cnt;
    logic            rsp_pend;
    logic [PW-1:0]   rsp_id;

    logic [NREQ-1:0] wr_gnt, rd_gnt;
    logic [PW-1:0]   wr_id, rd_id;
    logic            wr_any, rd_any;
    logic            active, clearing, wr_fire, rd_fire, collide;
    logic [AW-1:0]   wr_a_sel, rd_a_sel;
    logic [DW-1:0]   wr_d_sel, wr_m_sel;

    gf22_rr_arbiter #(.N(NREQ)) u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wr_valid),
        .accept  (wr_fire),
        .gnt     (wr_gnt),
        .gnt_id  (wr_id),
        .gnt_any (wr_any)
    );

    gf22_rr_arbiter #(.N(NREQ)) u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (rd_valid),
        .accept  (rd_fire),
        .gnt     (rd_gnt),
        .gnt_id  (rd_id),
        .gnt_any (rd_any)
    );

    assign wr_a_sel = wr_addr[int'(wr_id)*AW +: AW];
    assign wr_d_sel = wr_data[int'(wr_id)*DW +: DW];
    assign wr_m_sel = wr_mask[int'(wr_id)*DW +: DW];
    assign rd_a_sel = rd_addr[int'(rd_id)*AW +: AW];

    // Reset is folded in so every strobe is quiet while rst is held low.
    assign active   = rst && (state_q == ST_IDLE);
    assign clearing = rst && (state_q == ST_CLEAR);
    assign wr_fire  = active && wr_any;
    // A read that hits the address being written this cycle waits one cycle so it sees the new data.
    assign collide  = wr_fire && rd_any && (rd_a_sel == wr_a_sel);
    assign rd_fire  = active && rd_any && !collide;

    assign clear_busy  = (state_q == ST_CLEAR);
    assign rd_rsp_data = mem_q1;

    // Next state plus all handshake, memory-port and response outputs.
    always_comb begin
        state_d      = state_q;
        wr_ready     = '0;
        rd_ready     = '0;
        rd_rsp_valid = '0;
        mem_ce0      = 1'b0;
        mem_we0      = 1'b0;
        mem_a0       = '0;
        mem_d0       = '0;
        mem_wem0     = '0;
        mem_ce1      = 1'b0;
        mem_a1       = '0;
        case (state_q)
            ST_IDLE:  if (clear_req) state_d = ST_CLEAR;
            ST_CLEAR: if (clr_cnt == CLR_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (clearing) begin
            mem_ce0  = 1'b1;
            mem_we0  = 1'b1;
            mem_a0   = clr_cnt;
            mem_wem0 = '1;
        end else if (wr_fire) begin
            wr_ready = wr_gnt;
            mem_ce0  = 1'b1;
            mem_we0  = 1'b1;
            mem_a0   = wr_a_sel;
            mem_d0   = wr_d_sel;
            mem_wem0 = wr_m_sel;
        end
        if (rd_fire) begin
            rd_ready = rd_gnt;
            mem_ce1  = 1'b1;
            mem_a1   = rd_a_sel;
        end
        if (rsp_pend) rd_rsp_valid[rsp_id] = 1'b1;
    end

    // State, sweep counter (wraps back to 0 after the last address) and read-response tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RST_ST;
            clr_cnt  <= '0;
            rsp_pend <= 1'b0;
            rsp_id   <= '0;
        end else begin
            state_q  <= state_d;
            if (state_q == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
            rsp_pend <= rd_fire;
            if (rd_fire) rsp_id <= rd_id;
        end
    end

endmodule

// File: tb/tb_gf22_sram64_be_arbiter.sv
// tb/tb_gf22_sram64_be_arbiter.sv - directed and randomized bench for gf22_sram64_be_arbiter
module tb_gf22_sram64_be_arbiter;

    localparam int NREQ  = 4;
    localparam int AW    = 14;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << AW;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear_req = 1'b0;
    logic               clear_busy;
    logic [NREQ-1:0]    wr_valid = '0;
    logic [NREQ-1:0]    wr_ready;
    logic [NREQ*AW-1:0] wr_addr = '0;
    logic [NREQ*DW-1:0] wr_data = '0;
    logic [NREQ*DW-1:0] wr_mask = '0;
    logic [NREQ-1:0]    rd_valid = '0;
    logic [NREQ-1:0]    rd_ready;
    logic [NREQ*AW-1:0] rd_addr = '0;
    logic [NREQ-1:0]    rd_rsp_valid;
    logic [DW-1:0]      rd_rsp_data;
    logic               mem_ce0, mem_we0, mem_ce1;
    logic [AW-1:0]      mem_a0, mem_a1;
    logic [DW-1:0]      mem_d0, mem_wem0;
    logic [DW-1:0]      mem_q1;

    always #5 clk = ~clk;

    gf22_sram64_be_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(clear_busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .mem_ce0(mem_ce0), .mem_a0(mem_a0), .mem_d0(mem_d0), .mem_we0(mem_we0),
        .mem_wem0(mem_wem0), .mem_ce1(mem_ce1), .mem_a1(mem_a1), .mem_q1(mem_q1)
    );

    // Memory macro stand-in: bit-masked write port, 1-cycle registered read port.
    logic [DW-1:0] sram [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] <= {$urandom, $urandom} | 64'h1;
        mem_q1 <= '0;
    end
    always @(posedge clk) begin
        if (mem_ce0 && mem_we0) sram[mem_a0] <= (sram[mem_a0] & ~mem_wem0) | (mem_d0 & mem_wem0);
        if (mem_ce1) mem_q1 <= sram[mem_a1];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_write(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] m);
        @(negedge clk);
        wr_valid[r] = 1'b1;
        wr_addr[r*AW +: AW] = a;
        wr_data[r*DW +: DW] = d;
        wr_mask[r*DW +: DW] = m;
        #1;
        for (int n = 0; n < 50 && !wr_ready[r]; n++) begin
            @(negedge clk);
            #1;
        end
        check("wr_accept", 64'(wr_ready[r]), 64'd1);
        @(negedge clk);
        wr_valid[r] = 1'b0;
    endtask

    task automatic do_read(input int r, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                           input string tag);
        @(negedge clk);
        rd_valid[r] = 1'b1;
        rd_addr[r*AW +: AW] = a;
        #1;
        for (int n = 0; n < 50 && !rd_ready[r]; n++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_accept"}, 64'(rd_ready[r]), 64'd1);
        @(negedge clk);
        rd_valid[r] = 1'b0;
        #1;
        check({tag, "_rspv"}, 64'(rd_rsp_valid), 64'(oh(r)));
        check({tag, "_data"}, rd_rsp_data, exp);
    endtask

    // Called at a sample point; walks the sweep until it ends, times out, or reaches stop_at.
    task automatic run_sweep(input int stop_at, output int cyc, output bit seq_ok, output bit rdy_ok);
        cyc = 0;
        seq_ok = 1'b1;
        rdy_ok = 1'b1;
        while (clear_busy && cyc < 20000) begin
            if (stop_at >= 0 && int'(mem_a0) == stop_at) break;
            if (mem_a0 !== AW'(cyc) || mem_ce0 !== 1'b1 || mem_we0 !== 1'b1 ||
                mem_wem0 !== '1 || mem_d0 !== '0 || mem_ce1 !== 1'b0) seq_ok = 1'b0;
            if (wr_ready !== '0 || rd_ready !== '0) rdy_ok = 1'b0;
            cyc++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] pre [NREQ];
    logic [DW-1:0] ref_mem [int];
    bit   [NREQ-1:0] wv, rv;
    logic [AW-1:0] wa [NREQ];
    logic [AW-1:0] ra [NREQ];
    logic [DW-1:0] wd [NREQ];
    logic [DW-1:0] wm [NREQ];

    initial begin
        int cyc;
        bit sok, rok;
        int wptr, rptr, gw, gr, idx, pend_id;
        bit pend;
        logic [DW-1:0] pend_data, old;

        // Reset: valids held high must not leak into ready or memory strobes.
        rst = 1'b1;
        #1 rst = 1'b0;
        wr_valid = '1;
        rd_valid = '1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_rd_ready", 64'(rd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rd_rsp_valid), 64'd0);
        check("rst_ce0", 64'(mem_ce0), 64'd0);
        check("rst_we0", 64'(mem_we0), 64'd0);
        check("rst_ce1", 64'(mem_ce1), 64'd0);
        check("rst_busy", 64'(clear_busy), 64'd1);

        // Clear-on-reset sweep.
        @(negedge clk);
        wr_valid = '0;
        rd_valid = '0;
        rst = 1'b1;
        #1;
        run_sweep(-1, cyc, sok, rok);
        check("sweep1_len", 64'(cyc), 64'(DEPTH));
        check("sweep1_addr_seq", 64'(sok), 64'd1);
        check("sweep1_busy_low", 64'(clear_busy), 64'd0);
        do_read(3, 14'h0000, 64'd0, "clr_lo");
        do_read(3, 14'h3FFF, 64'd0, "clr_hi");

        // Preload through the write path.
        for (int i = 0; i < NREQ; i++) begin
            pre[i] = 64'hC0DE_0000_0000_0000 | (64'(i) << 32) | 64'h10 + 64'(i);
            do_write(i, AW'(14'h10 + i), pre[i], '1);
        end
        do_write(2, 14'h0200, 64'h1111_2222_3333_4444, '1);

        // Round-robin reads with all four requesters holding valid.
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            rd_valid[i] = 1'b1;
            rd_addr[i*AW +: AW] = AW'(14'h10 + i);
        end
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) check($sformatf("rr_grant%0d", k), 64'(rd_ready), 64'(oh(k % 4)));
            if (k > 0) begin
                check($sformatf("rr_rspv%0d", k), 64'(rd_rsp_valid), 64'(oh((k - 1) % 4)));
                check($sformatf("rr_data%0d", k), rd_rsp_data, pre[(k - 1) % 4]);
            end
            @(negedge clk);
            if (k == 4) rd_valid = '0;
            #1;
        end

        // Bit-masked write merges into existing data.
        do_write(1, 14'h0200, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_FFFF_FFFF);
        do_read(3, 14'h0200, 64'h1111_2222_FFFF_0000, "masked");

        // Same-address write/read collision.
        @(negedge clk);
        wr_valid[0] = 1'b1;
        wr_addr[0 +: AW] = 14'h0100;
        wr_data[0 +: DW] = {8{8'hAA}};
        wr_mask[0 +: DW] = '1;
        rd_valid[2] = 1'b1;
        rd_addr[2*AW +: AW] = 14'h0100;
        #1;
        check("coll_wr_ready", 64'(wr_ready), 64'(oh(0)));
        check("coll_rd_ready", 64'(rd_ready), 64'd0);
        check("coll_ce1", 64'(mem_ce1), 64'd0);
        @(negedge clk);
        wr_valid[0] = 1'b0;
        #1;
        check("coll_retry_ready", 64'(rd_ready), 64'(oh(2)));
        @(negedge clk);
        rd_valid[2] = 1'b0;
        #1;
        check("coll_rspv", 64'(rd_rsp_valid), 64'(oh(2)));
        check("coll_data", rd_rsp_data, {8{8'hAA}});

        // clear_req right behind an accepted read.
        @(negedge clk);
        rd_valid[1] = 1'b1;
        rd_addr[1*AW +: AW] = 14'h0200;
        #1;
        check("clrq_rd_ready", 64'(rd_ready), 64'(oh(1)));
        @(negedge clk);
        rd_valid[1] = 1'b0;
        clear_req = 1'b1;
        #1;
        check("clrq_rspv", 64'(rd_rsp_valid), 64'(oh(1)));
        check("clrq_data", rd_rsp_data, 64'h1111_2222_FFFF_0000);
        check("clrq_busy_pre", 64'(clear_busy), 64'd0);
        @(negedge clk);
        clear_req = 1'b0;
        wr_valid = '1;
        rd_valid = '1;
        #1;
        check("clrq_busy", 64'(clear_busy), 64'd1);
        run_sweep(32'h1234, cyc, sok, rok);
        check("sweep2_reach_1234", 64'(cyc), 64'h1234);
        check("sweep2_addr_seq", 64'(sok), 64'd1);
        check("sweep2_ready_low", 64'(rok), 64'd1);

        // Reset mid-sweep.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ce0", 64'(mem_ce0), 64'd0);
        check("midrst_we0", 64'(mem_we0), 64'd0);
        check("midrst_a0", 64'(mem_a0), 64'd0);
        check("midrst_ce1", 64'(mem_ce1), 64'd0);
        check("midrst_wr_ready", 64'(wr_ready), 64'd0);
        check("midrst_rd_ready", 64'(rd_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("restart_ce0", 64'(mem_ce0), 64'd1);
        check("restart_a0", 64'(mem_a0), 64'd0);
        run_sweep(-1, cyc, sok, rok);
        wr_valid = '0;
        rd_valid = '0;
        check("sweep3_len", 64'(cyc), 64'(DEPTH));
        check("sweep3_addr_seq", 64'(sok), 64'd1);
        check("sweep3_ready_low", 64'(rok), 64'd1);
        do_read(3, 14'h0200, 64'd0, "post_clear");

        // Randomized traffic against a reference model (pointers are 0 after the mid-sweep reset
        // and the read above from requester 3 wraps rd back to 0).
        wptr = 0;
        rptr = 0;
        pend = 1'b0;
        pend_id = 0;
        pend_data = '0;
        wv = '0;
        rv = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (!wv[i] && $urandom_range(0, 2) != 0) begin
                    wv[i] = 1'b1;
                    wa[i] = AW'($urandom_range(0, 7));
                    wd[i] = {$urandom, $urandom};
                    wm[i] = ($urandom_range(0, 1) != 0) ? '1 : {$urandom, $urandom};
                end
                if (!rv[i] && $urandom_range(0, 2) != 0) begin
                    rv[i] = 1'b1;
                    ra[i] = AW'($urandom_range(0, 7));
                end
                wr_valid[i] = wv[i];
                rd_valid[i] = rv[i];
                wr_addr[i*AW +: AW] = wa[i];
                wr_data[i*DW +: DW] = wd[i];
                wr_mask[i*DW +: DW] = wm[i];
                rd_addr[i*AW +: AW] = ra[i];
            end
            #1;
            gw = -1;
            gr = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (wptr + k) % NREQ;
                if (gw < 0 && wv[idx]) gw = idx;
                idx = (rptr + k) % NREQ;
                if (gr < 0 && rv[idx]) gr = idx;
            end
            if (gw >= 0 && gr >= 0 && wa[gw] == ra[gr]) gr = -1;
            check("rnd_wr_ready", 64'(wr_ready), (gw >= 0) ? 64'(oh(gw)) : 64'd0);
            check("rnd_rd_ready", 64'(rd_ready), (gr >= 0) ? 64'(oh(gr)) : 64'd0);
            check("rnd_ce0", 64'(mem_ce0), 64'(gw >= 0));
            check("rnd_ce1", 64'(mem_ce1), 64'(gr >= 0));
            if (pend) begin
                check("rnd_rspv", 64'(rd_rsp_valid), 64'(oh(pend_id)));
                check("rnd_data", rd_rsp_data, pend_data);
            end else begin
                check("rnd_rspv_idle", 64'(rd_rsp_valid), 64'd0);
            end
            pend = (gr >= 0);
            if (gr >= 0) begin
                pend_id = gr;
                pend_data = ref_mem.exists(int'(ra[gr])) ? ref_mem[int'(ra[gr])] : 64'd0;
                rv[gr] = 1'b0;
                rptr = (gr + 1) % NREQ;
            end
            if (gw >= 0) begin
                old = ref_mem.exists(int'(wa[gw])) ? ref_mem[int'(wa[gw])] : 64'd0;
                ref_mem[int'(wa[gw])] = (old & ~wm[gw]) | (wd[gw] & wm[gw]);
                wv[gw] = 1'b0;
                wptr = (gw + 1) % NREQ;
            end
        end
        @(negedge clk);
        wr_valid = '0;
        rd_valid = '0;
        #1;
        if (pend) begin
            check("rnd_last_rspv", 64'(rd_rsp_valid), 64'(oh(pend_id)));
            check("rnd_last_data", rd_rsp_data, pend_data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gf22_sram64_be_arbiter.md
Name: gf22_sram64_be_arbiter

Overview:
- Shares one 16384x64 byte-masked SRAM (one write port 0, one read port 1, 1-cycle read latency) between NREQ requesters.
- Round-robin arbitration runs independently on each port.
- Read responses are routed back to the requester that issued the read.
- A hardware clear engine zero-fills the whole memory after reset or on request.
- Sits between accelerator-local masters and the memory wrapper instance.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 14, memory address width (depth 2^AW)
DW, 64, data width; mask width equals DW
CLEAR_ON_RESET, 1, 1 = run the clear sweep automatically when reset releases

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-low
clear_req  in  1  single-cycle pulse; starts a zero-fill sweep
clear_busy  out  1  high while the sweep runs
wr_valid  in  NREQ  per-requester write request
wr_ready  out  NREQ  write accepted this cycle
wr_addr  in  NREQ*AW  write addresses, requester i in slice i
wr_data  in  NREQ*DW  write data
wr_mask  in  NREQ*DW  bit-enable mask, 1 = write bit
rd_valid  in  NREQ  per-requester read request
rd_ready  out  NREQ  read accepted this cycle
rd_addr  in  NREQ*AW  read addresses
rd_rsp_valid  out  NREQ  one-hot; read data valid for requester i
rd_rsp_data  out  DW  read data (shared bus)
mem_ce0  out  1  memory write-port enable
mem_a0  out  AW  memory write address
mem_d0  out  DW  memory write data
mem_we0  out  1  memory write enable
mem_wem0  out  DW  memory write mask
mem_ce1  out  1  memory read-port enable
mem_a1  out  AW  memory read address
mem_q1  in  DW  memory read data, valid 1 cycle after mem_ce1

Behaviour:
- Reset (rst low, asynchronous):
  - all ready, rd_rsp_valid and mem_ce*/mem_we0 outputs go 0.
  - Both round-robin pointers go to 0, so requester 0 has top priority.
  - Clear counter goes to 0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else IDLE; clear_busy = (state==CLEAR).
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_req=1.
  - CLEAR -> IDLE after the cycle that writes address 2^AW-1.
  - clear_req while in CLEAR is ignored.
- CLEAR state:
  - wr_ready = rd_ready = 0.
  - mem_ce0 = mem_we0 = 1, mem_wem0 = all ones, mem_d0 = 0, mem_a0 = counter; counter +1 per cycle.
  - Sweep lasts exactly 2^AW cycles. clear_busy drops the cycle after the last write.
  - mem_ce1 = 0.
- Arbitration in IDLE, combinational within the cycle:
  - Write grant = first asserted wr_valid at or after wr_ptr, searching cyclically upward.
  - Read grant uses rd_valid and rd_ptr the same way.
  - At most one wr_ready bit and one rd_ready bit is high per cycle; ready is asserted only where valid is high.
- Handshake:
  - A transfer occurs on valid & ready.
  - Requesters must hold valid, address, data and mask stable until ready.
  - ready may not depend on a requester dropping valid.
- Write transfer: mem_ce0 = mem_we0 = 1; mem_a0/d0/wem0 = the granted requester's slices. wr_ptr <= grant+1 (mod NREQ).
- Read transfer: mem_ce1 = 1 and mem_a1 = granted address; rd_ptr <= grant+1 (mod NREQ).
  - Next cycle: rd_rsp_valid = onehot(grant) from a registered id; rd_rsp_data = mem_q1 (combinational pass-through).
  - Responses have no backpressure.
  - Back-to-back reads from any requesters give one response per cycle.
- No-transfer cycle: mem_ce0/ce1 = 0, mem data/address outputs driven 0, pointers hold.
- Same-address collision: if the winning read address equals the winning write address in the same cycle:
  - the write proceeds;
  - the read is not granted and rd_ptr holds;
  - the read is retried next cycle and returns the newly written data.
- clear_req arriving while a read response is pending: the response is still delivered the next cycle, then CLEAR begins.
- rst asserted mid-sweep: the sweep restarts from address 0 when CLEAR_ON_RESET=1, otherwise the FSM returns to IDLE.
- Reads and writes from the same requester are unordered except for the collision rule above.

Decomposition:
- Package gf22_sram64_arb_pkg holds:
  - AW/DW defaults;
  - the FSM state enum (IDLE, CLEAR);
  - the clear-counter terminal value function.
- One sub-module, gf22_rr_arbiter (NREQ-wide round-robin grant with pointer update on accept), is instantiated twice: once for writes, once for reads.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> clear_busy high for exactly 16384 cycles, mem_a0 goes 0..16383, then reads of address 0x0000 and 0x3FFF return 0.
- Requesters 0..3 all hold rd_valid, addresses 0x10..0x13 -> grants in order 0,1,2,3,0; rd_rsp_valid one-hot one cycle after each grant with the matching preloaded data.
- Requester 1 writes 0xFFFF_0000_FFFF_0000 with mask 0x0000_0000_FFFF_FFFF to 0x0200, which holds 0x1111_2222_3333_4444 -> a later read returns 0x1111_2222_FFFF_0000.
- Same cycle: req0 writes 0xAA..AA to 0x0100 while req2 reads 0x0100 -> rd_ready[2]=0 that cycle; read granted the next cycle and returns 0xAA..AA.
- clear_req pulsed the cycle after a read is accepted -> read response still delivered; clear_busy rises; all ready stay low until the sweep ends.
- rst pulsed at sweep address 0x1234 -> outputs zeroed immediately; after release the sweep restarts at address 0.
